// File: rtl/serial_word_deser.sv
// -----------------------------------------------------------------------------
// serial_word_deser
//
// Serial-to-parallel word deserializer with sync-word frame alignment.
// Bits arrive MSB first, qualified by bit_vld. In HUNT the shift register is
// compared against SYNC_WORD after every valid bit. A match moves the block to
// LOCKED. In LOCKED, every WIDTH valid bits complete one word.
//
// A completed word equal to SYNC_WORD re-aligns the frame and is not output.
// Any other completed word goes to a single-entry valid/ready output register.
// If that register is still full and not being accepted, the new word is
// dropped and the sticky overflow flag is set.
//
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous active-high reset
//   bit_in    in   1      serial data bit, MSB first
//   bit_vld   in   1      bit_in qualifier
//   hunt_req  in   1      force return to alignment search
//   word_rdy  in   1      downstream accepts word_out this cycle
//   clr_ovf   in   1      clear the sticky overflow flag
//   word_out  out  WIDTH  registered deserialized word
//   word_vld  out  1      word_out holds an unaccepted word
//   locked    out  1      registered, high while in LOCKED
//   overflow  out  1      sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module serial_word_deser #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             hunt_req,
    input  logic             word_rdy,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    output logic             locked,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] word_q;
    logic             word_vld_q;
    logic             locked_q;
    logic             overflow_q;

    logic [WIDTH-1:0] shreg_d;
    logic             wrap_s;
    logic             word_done_s;
    logic             load_s;
    logic             ovf_set_s;

    // Post-shift value; both sync detection and word completion look at it.
    assign shreg_d = {shreg_q[WIDTH-2:0], bit_in};
    assign wrap_s  = (cnt_q == CW'(WIDTH - 1));

    // Word completion and output-register load/drop decisions.
    always_comb begin
        word_done_s = 1'b0;
        load_s      = 1'b0;
        ovf_set_s   = 1'b0;
        // hunt_req wins over a word completing on the same edge.
        if ((state_q == ST_LOCKED) && bit_vld && !hunt_req && wrap_s
            && (shreg_d != SYNC_WORD)) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
        if (word_done_s) begin
            load_s    = !word_vld_q || word_rdy;
            ovf_set_s = word_vld_q && !word_rdy;
        end else begin
            load_s    = 1'b0;
            ovf_set_s = 1'b0;
        end
    end

    // Alignment FSM, shift register, bit counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            shreg_q    <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // A set on the same edge as a clear leaves the flag set.
            if (ovf_set_s) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end else begin
                overflow_q <= overflow_q;
            end

            // The output register keeps its word across a hunt_req.
            if (load_s) begin
                word_q     <= shreg_d;
                word_vld_q <= 1'b1;
            end else if (word_vld_q && word_rdy) begin
                word_vld_q <= 1'b0;
            end else begin
                word_vld_q <= word_vld_q;
            end

            if (hunt_req) begin
                state_q  <= ST_HUNT;
                shreg_q  <= '0;
                cnt_q    <= '0;
                locked_q <= 1'b0;
            end else if (bit_vld) begin
                shreg_q <= shreg_d;
                case (state_q)
                    ST_HUNT: begin
                        cnt_q <= '0;
                        if (shreg_d == SYNC_WORD) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= ST_HUNT;
                            locked_q <= 1'b0;
                        end
                    end
                    ST_LOCKED: begin
                        // Re-sync words also wrap here, which keeps alignment.
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                        if (wrap_s) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q  <= ST_HUNT;
                        cnt_q    <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end else begin
                shreg_q <= shreg_q;
                cnt_q   <= cnt_q;
            end
        end
    end

    assign word_out = word_q;
    assign word_vld = word_vld_q;
    assign locked   = locked_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_word_deser.sv
// -----------------------------------------------------------------------------
// tb_serial_word_deser
//
// Self-checking bench for serial_word_deser (WIDTH=8, SYNC_WORD=8'hA5).
// Each word the bench expects to be delivered is pushed to a scoreboard queue
// when its bits are driven. A monitor pops and compares the queue whenever a
// word is handed over (word_vld && word_rdy).
// -----------------------------------------------------------------------------
module tb_serial_word_deser;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_vld;
    logic       hunt_req;
    logic       word_rdy;
    logic       clr_ovf;
    logic [7:0] word_out;
    logic       word_vld;
    logic       locked;
    logic       overflow;

    int checks_r;
    int errors_r;

    logic [7:0] sb_q[$];

    serial_word_deser #(
        .WIDTH     (8),
        .SYNC_WORD (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .hunt_req (hunt_req),
        .word_rdy (word_rdy),
        .clr_ovf  (clr_ovf),
        .word_out (word_out),
        .word_vld (word_vld),
        .locked   (locked),
        .overflow (overflow)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: inputs are stable at the falling edge, so a
    // handshake seen here happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && word_vld && word_rdy) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
            end else begin
                check_val("word", 32'(word_out), 32'(sb_q.pop_front()));
            end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle gap cycles first, then one valid bit; returns just after its edge.
    task automatic send_bit(input logic b, input int gap);
        bit_vld = 1'b0;
        repeat (gap) tick();
        bit_in  = b;
        bit_vld = 1'b1;
        tick();
        bit_vld = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int maxgap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
        end
    endtask

    // Sync word with a lock check before and after its last bit.
    task automatic send_sync(input int maxgap, input string tag);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 1; i--) begin
            send_bit(s[i], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
        end
        check_val({tag, "_locked_pre"}, 32'(locked), 32'd0);
        send_bit(s[0], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
        check_val({tag, "_locked_post"}, 32'(locked), 32'd1);
    endtask

    task automatic pulse_hunt();
        hunt_req = 1'b1;
        tick();
        hunt_req = 1'b0;
    endtask

    initial begin
        logic [7:0] tail;
        checks_r = 0;
        errors_r = 0;
        rst      = 1'b1;
        bit_in   = 1'b0;
        bit_vld  = 1'b0;
        hunt_req = 1'b0;
        word_rdy = 1'b1;
        clr_ovf  = 1'b0;
        repeat (3) tick();
        check_val("rst_word_out", 32'(word_out), 32'd0);
        check_val("rst_word_vld", 32'(word_vld), 32'd0);
        check_val("rst_locked",   32'(locked),   32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Lock, then one data word visible for one cycle.
        send_sync(0, "t1");
        sb_q.push_back(8'h3C);
        send_word(8'h3C, 0);
        check_val("t1_vld",  32'(word_vld), 32'd1);
        check_val("t1_word", 32'(word_out), 32'h3C);
        tick();
        check_val("t1_vld_clear", 32'(word_vld), 32'd0);

        // Backpressure: second word dropped, overflow sticky until cleared.
        word_rdy = 1'b0;
        sb_q.push_back(8'h11);
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        check_val("t2_hold_word", 32'(word_out), 32'h11);
        check_val("t2_hold_vld",  32'(word_vld), 32'd1);
        check_val("t2_overflow",  32'(overflow), 32'd1);
        tick();
        check_val("t2_ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_val("t2_ovf_clear", 32'(overflow), 32'd0);
        check_val("t2_still_11",  32'(word_out), 32'h11);
        word_rdy = 1'b1;
        tick();
        check_val("t2_vld_clear", 32'(word_vld), 32'd0);

        // In-lock sync word is swallowed.
        send_word(8'hA5, 0);
        check_val("t3_sync_no_vld", 32'(word_vld), 32'd0);
        check_val("t3_still_lock",  32'(locked),   32'd1);
        sb_q.push_back(8'h5A);
        send_word(8'h5A, 0);
        check_val("t3_word",     32'(word_out), 32'h5A);
        check_val("t3_overflow", 32'(overflow), 32'd0);
        tick();

        // Same stream with bit_vld gaps, after a forced re-hunt.
        pulse_hunt();
        check_val("t4_unlocked", 32'(locked), 32'd0);
        send_sync(3, "t4");
        sb_q.push_back(8'h3C);
        send_word(8'h3C, 3);
        check_val("t4_word", 32'(word_out), 32'h3C);
        repeat (2) tick();

        // hunt_req mid-word, then 11111 must not lock or emit.
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        pulse_hunt();
        check_val("t5_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        check_val("t5_no_lock", 32'(locked),   32'd0);
        check_val("t5_no_vld",  32'(word_vld), 32'd0);

        // Async reset mid-cycle with everything set, then a fresh lock.
        send_sync(0, "t6a");
        word_rdy = 1'b0;
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        tail = 8'hC3;
        for (int i = 7; i >= 5; i--) send_bit(tail[i], 0);
        check_val("t6_pre_vld", 32'(word_vld), 32'd1);
        check_val("t6_pre_ovf", 32'(overflow), 32'd1);
        check_val("t6_pre_lck", 32'(locked),   32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_rst_word", 32'(word_out), 32'd0);
        check_val("t6_rst_vld",  32'(word_vld), 32'd0);
        check_val("t6_rst_lck",  32'(locked),   32'd0);
        check_val("t6_rst_ovf",  32'(overflow), 32'd0);
        sb_q.delete();
        tick();
        rst      = 1'b0;
        word_rdy = 1'b1;
        tick();
        send_sync(0, "t6b");
        sb_q.push_back(8'h3C);
        send_word(8'h3C, 0);
        check_val("t6_word", 32'(word_out), 32'h3C);
        repeat (3) tick();

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
